// File: rtl/seg7_scan_if.sv
// Bundle between a display producer and the 7-segment scan driver.
// master drives frame content and enable; slave is the scan driver.
interface seg7_scan_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic [3:0]            num;
  logic                  dp_out;
  logic [DIGITS-1:0]     dig_sel;
  logic                  frame_done;

  modport master (
    output en, bcd_in, dp_in, lz_blank,
    input  num, dp_out, dig_sel, frame_done
  );

  modport slave (
    input  en, bcd_in, dp_in, lz_blank,
    output num, dp_out, dig_sel, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan driver feeding a BCD-to-segment decoder; latches a whole
// frame at LOAD, gaps all selects between slots and optionally blanks leading zeros.
//
// state  | meaning
// LOAD   | capture frame into shadow regs (1 cycle), or parked while en=0
// GAP    | all selects off for GAP_CYC cycles before a slot
// ON     | select of digit idx active (unless blanked) for SCAN_DIV cycles
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GAP_CYC  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  seg7_scan_if.slave     bus
);

  localparam int MAXC = (SCAN_DIV > GAP_CYC) ? SCAN_DIV : GAP_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_ON   = 2'd2;

  localparam logic [CW-1:0]     GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0]     SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF   = '1;

  logic [1:0]          state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                shadow_lz_q, shadow_lz_d;
  logic [3:0]          num_q, num_d;
  logic                dp_out_q, dp_out_d;
  logic [DIGITS-1:0]   dig_sel_q, dig_sel_d;
  logic                frame_done_q, frame_done_d;

  logic [DIGITS-1:0]   blank;
  logic [IW-1:0]       nxt_idx;

  // A digit is blanked when it and every more significant digit are zero.
  always_comb begin
    logic zero_above;
    blank      = '0;
    zero_above = shadow_lz_q;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above && (shadow_bcd_q[4*k +: 4] == 4'd0);
      blank[k]   = zero_above;
    end
  end

  assign nxt_idx = idx_q + IW'(1);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    shadow_lz_d  = shadow_lz_q;
    num_d        = num_q;
    dp_out_d     = dp_out_q;
    dig_sel_d    = SEL_OFF;
    frame_done_d = 1'b0;

    if (!bus.en) begin
      state_d = S_LOAD;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          shadow_bcd_d = bus.bcd_in;
          shadow_dp_d  = bus.dp_in;
          shadow_lz_d  = bus.lz_blank;
          num_d        = bus.bcd_in[3:0];
          dp_out_d     = bus.dp_in[0];
          idx_d        = '0;
          cnt_d        = '0;
          state_d      = S_GAP;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d     = '0;
            state_d   = S_ON;
            dig_sel_d = blank[idx_q] ? SEL_OFF : ~(DIGITS'(1) << idx_q);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_ON: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_d = '0;
            if (idx_q == IDX_LAST) begin
              state_d      = S_LOAD;
              frame_done_d = 1'b1;
            end else begin
              idx_d    = nxt_idx;
              num_d    = shadow_bcd_q[4*int'(nxt_idx) +: 4];
              dp_out_d = shadow_dp_q[nxt_idx];
              state_d  = S_GAP;
            end
          end else begin
            cnt_d     = cnt_q + CW'(1);
            dig_sel_d = dig_sel_q;
          end
        end
        default: begin
          state_d = S_LOAD;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_LOAD;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      shadow_lz_q  <= 1'b0;
      num_q        <= 4'd0;
      dp_out_q     <= 1'b0;
      dig_sel_q    <= SEL_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      shadow_lz_q  <= shadow_lz_d;
      num_q        <= num_d;
      dp_out_q     <= dp_out_d;
      dig_sel_q    <= dig_sel_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.num        = num_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.dig_sel    = dig_sel_q;
  assign bus.frame_done = frame_done_q;

endmodule
